// File: rtl/sha1_pkg.sv
// Shared SHA-1 constants and controller state encoding.
package sha1_pkg;

    localparam logic [31:0] H0 = 32'h67452301;
    localparam logic [31:0] H1 = 32'hEFCDAB89;
    localparam logic [31:0] H2 = 32'h98BADCFE;
    localparam logic [31:0] H3 = 32'h10325476;
    localparam logic [31:0] H4 = 32'hC3D2E1F0;
    localparam logic [159:0] IV = {H0, H1, H2, H3, H4};

    localparam int ROUNDS_DEF = 80;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINAL,
        DONE
    } state_t;

endpackage

// File: rtl/sha1_w_sched.sv
// 16-word circular SHA-1 message schedule; wt is combinational for index j.
import sha1_pkg::*;

module sha1_w_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [511:0] blk_data,
    input  logic         advance,
    input  logic [7:0]   j,
    output logic [31:0]  wt
);

    logic [31:0] sched_buf [16];
    logic [31:0] blk_word  [16];
    logic [3:0]  jl;
    logic [3:0]  idx_m3;
    logic [3:0]  idx_m8;
    logic [3:0]  idx_m14;
    logic [31:0] mix;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_word
            assign blk_word[gi] = blk_data[511 - 32*gi -: 32];
        end
    endgenerate

    // Negative offsets wrap naturally in 4-bit arithmetic.
    assign jl      = j[3:0];
    assign idx_m3  = jl + 4'd13;
    assign idx_m8  = jl + 4'd8;
    assign idx_m14 = jl + 4'd2;
    assign mix     = sched_buf[idx_m3] ^ sched_buf[idx_m8] ^ sched_buf[idx_m14] ^ sched_buf[jl];
    assign wt      = (j < 8'd16) ? sched_buf[jl] : {mix[30:0], mix[31]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) sched_buf[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) sched_buf[i] <= blk_word[i];
        end else if (advance && j >= 8'd16) begin
            sched_buf[jl] <= wt;
        end
    end

endmodule

// File: rtl/sha1_round_ctrl.sv
// SHA-1 block controller: issues ROUNDS rounds to an external round unit and
// folds the result into the chaining value H.
import sha1_pkg::*;

module sha1_round_ctrl #(
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    output logic         rnd_valid,
    output logic [159:0] rnd_din,
    output logic [31:0]  rnd_w,
    output logic [7:0]   rnd_num,
    input  logic [159:0] rnd_dout,
    input  logic         rnd_ready,
    output logic         dig_valid,
    output logic [159:0] dig_data,
    output logic         busy
);

    state_t        state_reg;
    logic [7:0]    t_reg;
    logic [159:0]  h_reg;
    logic [159:0]  abcde_reg;
    logic [159:0]  h_sum;
    logic          blk_ready_reg;
    logic          rnd_valid_reg;
    logic [159:0]  rnd_din_reg;
    logic [7:0]    rnd_num_reg;
    logic          dig_valid_reg;
    logic          busy_reg;
    logic [31:0]   wt;
    logic          sched_load;
    logic          sched_advance;

    assign sched_load    = (state_reg == IDLE) && blk_valid;
    assign sched_advance = (state_reg == ISSUE);

    sha1_w_sched u_sched (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sched_load),
        .blk_data (blk_data),
        .advance  (sched_advance),
        .j        (t_reg - 8'd1),
        .wt       (wt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sum
            assign h_sum[159 - 32*gi -: 32] = h_reg[159 - 32*gi -: 32] + abcde_reg[159 - 32*gi -: 32];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            t_reg         <= '0;
            h_reg         <= IV;
            abcde_reg     <= '0;
            blk_ready_reg <= 1'b1;
            rnd_valid_reg <= 1'b0;
            rnd_din_reg   <= '0;
            rnd_num_reg   <= '0;
            dig_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            rnd_valid_reg <= 1'b0;
            dig_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (blk_valid) begin
                        if (blk_first) h_reg <= IV;
                        abcde_reg     <= blk_first ? IV : h_reg;
                        rnd_din_reg   <= blk_first ? IV : h_reg;
                        t_reg         <= 8'd1;
                        rnd_num_reg   <= 8'd1;
                        rnd_valid_reg <= 1'b1;
                        blk_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: state_reg <= WAIT;
                WAIT: begin
                    if (rnd_ready) begin
                        abcde_reg <= rnd_dout;
                        if (t_reg == 8'(ROUNDS)) begin
                            state_reg <= FINAL;
                        end else begin
                            t_reg         <= t_reg + 8'd1;
                            rnd_num_reg   <= t_reg + 8'd1;
                            rnd_din_reg   <= rnd_dout;
                            rnd_valid_reg <= 1'b1;
                            state_reg     <= ISSUE;
                        end
                    end
                end
                FINAL: begin
                    h_reg         <= h_sum;
                    dig_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    blk_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The schedule word is only meaningful alongside the issue strobe.
    assign rnd_w     = (state_reg == ISSUE) ? wt : '0;
    assign blk_ready = blk_ready_reg;
    assign rnd_valid = rnd_valid_reg;
    assign rnd_din   = rnd_din_reg;
    assign rnd_num   = rnd_num_reg;
    assign dig_valid = dig_valid_reg;
    assign dig_data  = h_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_sha1_round_ctrl.sv
// Directed bench for sha1_round_ctrl with a behavioural SHA-1 round unit.
module tb_sha1_round_ctrl;

    localparam logic [159:0] IV_C    = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_EMP = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] DIG_TWO = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    logic         clk;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         rnd_valid;
    logic [159:0] rnd_din;
    logic [31:0]  rnd_w;
    logic [7:0]   rnd_num;
    logic [159:0] rnd_dout;
    logic         rnd_ready;
    logic         dig_valid;
    logic [159:0] dig_data;
    logic         busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rd_delay = 1;

    sha1_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_first (blk_first),
        .rnd_valid (rnd_valid),
        .rnd_din   (rnd_din),
        .rnd_w     (rnd_w),
        .rnd_num   (rnd_num),
        .rnd_dout  (rnd_dout),
        .rnd_ready (rnd_ready),
        .dig_valid (dig_valid),
        .dig_data  (dig_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [159:0] sha1_round(input logic [159:0] s, input logic [31:0] w, input int t);
        logic [31:0] a, b, c, d, e, f, k, tmp;
        a = s[159:128]; b = s[127:96]; c = s[95:64]; d = s[63:32]; e = s[31:0];
        if (t <= 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
        else if (t <= 40) begin f = b ^ c ^ d;                    k = 32'h6ed9eba1; end
        else if (t <= 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
        else              begin f = b ^ c ^ d;                    k = 32'hca62c1d6; end
        tmp = {a[26:0], a[31:27]} + f + e + k + w;
        return {tmp, a, {b[1:0], b[31:2]}, c, d};
    endfunction

    // Round unit: answers rd_delay cycles after the issue cycle.
    initial begin
        int cnt;
        logic [159:0] res;
        cnt = 0;
        res = '0;
        rnd_ready = 1'b0;
        rnd_dout = '0;
        forever begin
            @(negedge clk);
            rnd_ready = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    rnd_ready = 1'b1;
                    rnd_dout = res;
                end
            end else if (rnd_valid) begin
                res = sha1_round(rnd_din, rnd_w, int'(rnd_num));
                cnt = rd_delay;
            end
        end
    end

    typedef struct {
        string        name;
        logic [511:0] data;
        logic         first;
        int           dly;
        bit           chk_dig;
        logic [159:0] dig;
        int           lat;
    } vec_t;

    vec_t vecs[5];

    task automatic run_block(input logic [511:0] data, input logic first, input int dly,
                             input bit pulse, output logic [159:0] dig, output int lat, output bit seen);
        rd_delay = dly;
        @(negedge clk);
        blk_data  = data;
        blk_first = first;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        chk("issue1 rnd_valid", rnd_valid, 1'b1);
        chk("issue1 rnd_num", rnd_num, 8'd1);
        chk("issue1 rnd_w", rnd_w, data[511:480]);
        chk("issue1 busy", busy, 1'b1);
        chk("issue1 blk_ready", blk_ready, 1'b0);
        lat = 1;
        seen = 1'b0;
        dig = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            lat++;
            if (pulse && rnd_valid && rnd_num == 8'd40) begin
                blk_valid = 1'b1;
                blk_first = 1'b1;
                blk_data  = {16{32'hdeadbeef}};
                chk("blk_ready while busy", blk_ready, 1'b0);
            end else begin
                blk_valid = 1'b0;
            end
            if (dig_valid) begin
                seen = 1'b1;
                dig = dig_data;
                break;
            end
        end
    endtask

    initial begin
        logic [511:0] abc_blk, emp_blk, two1_blk, two2_blk;
        logic [159:0] dig;
        int lat, k1, k2, dv_cnt;
        bit seen;

        abc_blk  = {32'h61626380, {14{32'h0}}, 32'h00000018};
        emp_blk  = {32'h80000000, {15{32'h0}}};
        two1_blk = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two2_blk = {{15{32'h0}}, 32'h000001c0};

        vecs[0] = '{"abc first=0 after reset", abc_blk,  1'b0, 1, 1'b1, DIG_ABC, 162};
        vecs[1] = '{"empty",                   emp_blk,  1'b1, 1, 1'b1, DIG_EMP, 162};
        vecs[2] = '{"two-block #1",            two1_blk, 1'b1, 1, 1'b0, '0,      162};
        vecs[3] = '{"two-block #2 chained",    two2_blk, 1'b0, 1, 1'b1, DIG_TWO, 162};
        vecs[4] = '{"abc delay3",              abc_blk,  1'b1, 3, 1'b1, DIG_ABC, 322};

        rst_n = 1'b0;
        blk_valid = 1'b0;
        blk_first = 1'b0;
        blk_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset blk_ready", blk_ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset rnd_valid", rnd_valid, 1'b0);
        chk("reset rnd_din", rnd_din, '0);
        chk("reset rnd_w", rnd_w, '0);
        chk("reset rnd_num", rnd_num, '0);
        chk("reset dig_valid", dig_valid, 1'b0);
        chk("reset dig_data", dig_data, IV_C);

        for (int v = 0; v < 5; v++) begin
            run_block(vecs[v].data, vecs[v].first, vecs[v].dly, (v == 4), dig, lat, seen);
            $display("vector %0d (%s): digest %h latency %0d", v, vecs[v].name, dig, lat);
            chk({vecs[v].name, " dig_valid seen"}, seen, 1'b1);
            chk({vecs[v].name, " latency"}, lat, vecs[v].lat);
            if (vecs[v].chk_dig) chk({vecs[v].name, " digest"}, dig, vecs[v].dig);
            @(negedge clk);
            chk({vecs[v].name, " dig_valid one cycle"}, dig_valid, 1'b0);
            chk({vecs[v].name, " blk_ready after done"}, blk_ready, 1'b1);
            chk({vecs[v].name, " dig_data held"}, dig_data, dig);
        end

        // Back-to-back: blk_valid held high across a whole block.
        rd_delay = 1;
        k1 = -1;
        k2 = -1;
        dig = '0;
        @(negedge clk);
        blk_data = abc_blk;
        blk_first = 1'b1;
        blk_valid = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (dig_valid) dig = dig_data;
            if (rnd_valid && rnd_num == 8'd1) begin
                if (k1 < 0) k1 = c;
                else begin k2 = c; break; end
            end
        end
        blk_valid = 1'b0;
        $display("back-to-back: accepts %0d cycles apart, first digest %h", k2 - k1, dig);
        chk("b2b spacing", k2 - k1, 163);
        chk("b2b first digest", dig, DIG_ABC);
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (dig_valid) begin seen = 1'b1; dig = dig_data; break; end
        end
        $display("back-to-back: second digest %h", dig);
        chk("b2b second seen", seen, 1'b1);
        chk("b2b second digest", dig, DIG_ABC);

        // Stray blk_valid at round 40, reset at round 50.
        @(negedge clk);
        rd_delay = 1;
        blk_data = abc_blk;
        blk_first = 1'b1;
        blk_valid = 1'b1;
        dv_cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            blk_valid = 1'b0;
            if (dig_valid) dv_cnt++;
            if (rnd_valid && rnd_num == 8'd40) begin
                blk_valid = 1'b1;
                blk_data = {16{32'h12345678}};
            end
            if (rnd_valid && rnd_num == 8'd50) begin
                rst_n = 1'b0;
                seen = 1'b1;
                break;
            end
        end
        chk("abort reached round 50", seen, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("abort: post-reset busy=%0b blk_ready=%0b rnd_num=%0d dig_data=%h", busy, blk_ready, rnd_num, dig_data);
        chk("abort blk_ready", blk_ready, 1'b1);
        chk("abort busy", busy, 1'b0);
        chk("abort rnd_valid", rnd_valid, 1'b0);
        chk("abort rnd_din", rnd_din, '0);
        chk("abort rnd_num", rnd_num, '0);
        chk("abort rnd_w", rnd_w, '0);
        chk("abort dig_data", dig_data, IV_C);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (dig_valid || busy) dv_cnt++;
        end
        chk("abort no dig_valid/busy", dv_cnt, 0);

        run_block(abc_blk, 1'b1, 1, 1'b0, dig, lat, seen);
        $display("after abort: abc digest %h latency %0d", dig, lat);
        chk("after abort seen", seen, 1'b1);
        chk("after abort digest", dig, DIG_ABC);
        chk("after abort latency", lat, 162);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sha1_round_ctrl.md
SHA1_ROUND_CTRL -- requirements
Module: sha1_round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 80: number of round issues per 512-bit block.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port blk_valid, input, 1: message block offered.
REQ-005 SHALL have port blk_ready, output, 1: controller can accept a block.
REQ-006 SHALL have port blk_data, input, 512: padded block, word W0 = blk_data[511:480].
REQ-007 SHALL have port blk_first, input, 1: first block of a message; reload H with the SHA-1 IV.
REQ-008 SHALL have port rnd_valid, output, 1: one-cycle round issue strobe to the round unit.
REQ-009 SHALL have port rnd_din, output, 160: working state {A,B,C,D,E} for the issued round.
REQ-010 SHALL have port rnd_w, output, 32: schedule word Wt for the issued round.
REQ-011 SHALL have port rnd_num, output, 8: round number, 1..ROUNDS.
REQ-012 SHALL have port rnd_dout, input, 160: round result {A,B,C,D,E}.
REQ-013 SHALL have port rnd_ready, input, 1: rnd_dout is valid this cycle.
REQ-014 SHALL have port dig_valid, output, 1: one-cycle digest strobe.
REQ-015 SHALL have port dig_data, output, 160: {H0,H1,H2,H3,H4}, held until the next update.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT, FINAL, DONE.
REQ-018 IDLE: blk_ready=1; on blk_valid, capture W0..W15 into the schedule buffer, load H with the IV if blk_first, load abcde from H (IV if blk_first), set t=1, go to ISSUE.
REQ-019 ISSUE: rnd_valid=1 for exactly one cycle with rnd_din=abcde, rnd_w=Wt, rnd_num=t; go to WAIT.
REQ-020 WAIT: on rnd_ready, abcde <= rnd_dout; if t==ROUNDS go to FINAL, else t <= t+1 and go to ISSUE. Without rnd_ready, remain in WAIT indefinitely.
REQ-021 SHALL ignore rnd_ready in all states except WAIT.
REQ-022 Schedule, for 0-based j = t-1: if j<16, Wt = buf[j]; else Wt = rotl1(buf[(j-3)&15] ^ buf[(j-8)&15] ^ buf[(j-14)&15] ^ buf[j&15]), written back to buf[j&15] in the ISSUE cycle.
REQ-023 FINAL: Hi <= Hi + abcde word i, modulo 2^32 with no carry between words; go to DONE.
REQ-024 DONE: dig_valid=1 for one cycle, dig_data = updated H; go to IDLE.
REQ-025 SHALL keep blk_ready=0 whenever busy=1; blk_valid while busy SHALL be ignored and SHALL NOT corrupt state.
REQ-026 Latency: with rnd_ready asserted in the cycle after each rnd_valid, dig_valid SHALL occur 2*ROUNDS+2 cycles after the accept cycle (162 for ROUNDS=80).
REQ-027 Each cycle of rnd_ready delay SHALL add exactly one cycle to the latency.
REQ-028 With blk_first=0, SHALL chain from the H of the previous block.
REQ-029 SHALL accept blk_first=0 on the first block after reset; H already holds the IV, so the result is identical to blk_first=1.
REQ-030 The next block SHALL be accepted no earlier than the cycle after DONE; back-to-back throughput is one block per 2*ROUNDS+3 cycles.

Reset
REQ-031 While rst_n=0 at a clock edge: state=IDLE; t=0; H=IV (67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0); abcde=0; schedule buffer=0.
REQ-032 Output reset values: blk_ready=1 once state=IDLE; rnd_valid=0, rnd_din=0, rnd_w=0, rnd_num=0, dig_valid=0, dig_data=IV, busy=0.
REQ-033 Reset mid-operation SHALL abort the block with no dig_valid; any late rnd_ready SHALL be ignored.

Structure
REQ-034 Package sha1_pkg SHALL hold the IV constants H0..H4, ROUNDS_DEF=80, and the FSM state enum.
REQ-035 The 16x32 circular schedule buffer and the Wt expansion SHALL be the sub-module sha1_w_sched (load, advance, index j; outputs Wt).
REQ-036 All outputs except rnd_w SHALL be registered.

Verification
REQ-037 Bench SHALL use a golden 1-cycle round model answering rnd_valid with rnd_ready in the next cycle.
REQ-038 "abc" single padded block, blk_first=1 -> dig_data a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, dig_valid 162 cycles after accept.
REQ-039 Empty message block -> da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
REQ-040 Two-block "abcdbcdecdef...nopq" (first=1, then first=0) -> 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
REQ-041 Round model delays rnd_ready by 3 cycles for "abc" -> same digest, dig_valid at cycle 322.
REQ-042 blk_valid pulsed at round 40, then rst_n low for 1 cycle at round 50 -> no dig_valid; outputs at reset values; a following "abc" block gives the correct digest.
